// File: rtl/wb_unit.sv
// Writeback stage: selects the result source, extracts and extends load data, holds the
// instruction while a data-memory response is outstanding, and drives the register-file write.
module wb_unit #(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5,
    parameter int CNT_WIDTH      = 64
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      flush_i,
    input  logic                      valid_i,
    output logic                      ready_o,
    input  logic [1:0]                src_sel_i,
    input  logic                      reg_we_i,
    input  logic [REG_ADDR_WIDTH-1:0] dest_reg_i,
    input  logic [DATA_WIDTH-1:0]     alu_result_i,
    input  logic [DATA_WIDTH-1:0]     pc_plus4_i,
    input  logic [DATA_WIDTH-1:0]     csr_rdata_i,
    input  logic [1:0]                load_size_i,
    input  logic                      load_unsigned_i,
    input  logic                      mem_rvalid_i,
    input  logic [DATA_WIDTH-1:0]     mem_rdata_i,
    output logic                      rf_we_o,
    output logic [REG_ADDR_WIDTH-1:0] rf_waddr_o,
    output logic [DATA_WIDTH-1:0]     rf_wdata_o,
    output logic                      load_pending_o,
    output logic [REG_ADDR_WIDTH-1:0] pending_reg_o,
    output logic                      retire_o,
    output logic [CNT_WIDTH-1:0]      instret_o
);

    localparam int OFF_WIDTH = $clog2(DATA_WIDTH / 8);

    localparam logic [1:0] SRC_ALU = 2'd0;
    localparam logic [1:0] SRC_MEM = 2'd1;
    localparam logic [1:0] SRC_PC4 = 2'd2;
    localparam logic [1:0] SRC_CSR = 2'd3;

    localparam logic [1:0] SIZE_B = 2'd0;
    localparam logic [1:0] SIZE_H = 2'd1;
    localparam logic [1:0] SIZE_D = 2'd3;

    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic {
        IDLE,
        WAIT_MEM
    } state_t;

    state_t                    state;
    logic [REG_ADDR_WIDTH-1:0] pend_rd;
    logic                      pend_we;
    logic [1:0]                pend_size;
    logic                      pend_unsigned;
    logic [OFF_WIDTH-1:0]      pend_off;

    logic                      waiting;
    logic                      accept;
    logic                      is_mem;
    logic                      complete_idle;
    logic                      complete_wait;
    logic                      done;
    logic                      write_en;
    logic [REG_ADDR_WIDTH-1:0] done_rd;
    logic                      done_we;
    logic [DATA_WIDTH-1:0]     done_val;

    logic [1:0]                ld_size;
    logic                      ld_unsigned;
    logic [OFF_WIDTH-1:0]      ld_off;
    logic [DATA_WIDTH-1:0]     ld_shifted;
    logic [DATA_WIDTH-1:0]     ld_mask;
    logic                      ld_sign;
    logic [DATA_WIDTH-1:0]     load_value;
    logic [DATA_WIDTH-1:0]     src_value;
    int                        ld_bits;
    int                        ld_shamt;

    assign waiting        = (state == WAIT_MEM);
    assign ready_o        = (state == IDLE) && !rst_i;
    assign load_pending_o = waiting;
    assign pending_reg_o  = pend_rd;
    assign accept         = valid_i && ready_o && !flush_i;
    assign is_mem         = (src_sel_i == SRC_MEM);

    assign ld_size     = waiting ? pend_size     : load_size_i;
    assign ld_unsigned = waiting ? pend_unsigned : load_unsigned_i;
    assign ld_off      = waiting ? pend_off      : alu_result_i[OFF_WIDTH-1:0];

    // Extraction is done as shift-then-mask so one path serves both 32- and 64-bit builds;
    // a D request on a 32-bit build degenerates to the full-word case.
    always_comb begin
        ld_bits  = 32;
        ld_shamt = 0;
        case (ld_size)
            SIZE_B: begin
                ld_bits  = 8;
                ld_shamt = 8 * int'(ld_off);
            end
            SIZE_H: begin
                ld_bits  = 16;
                ld_shamt = 16 * int'(ld_off >> 1);
            end
            default: begin
                if (DATA_WIDTH == 64 && ld_size == SIZE_D) begin
                    ld_bits  = 64;
                    ld_shamt = 0;
                end else if (DATA_WIDTH == 64) begin
                    ld_bits  = 32;
                    ld_shamt = 32 * int'(ld_off[OFF_WIDTH-1]);
                end else begin
                    ld_bits  = 32;
                    ld_shamt = 0;
                end
            end
        endcase
        ld_shifted = mem_rdata_i >> ld_shamt;
        ld_mask    = {DATA_WIDTH{1'b1}} >> (DATA_WIDTH - ld_bits);
        ld_sign    = !ld_unsigned && (|(ld_shifted & (ld_mask ^ (ld_mask >> 1))));
        load_value = (ld_shifted & ld_mask) | (ld_sign ? ~ld_mask : '0);
    end

    always_comb begin
        src_value = alu_result_i;
        case (src_sel_i)
            SRC_ALU: src_value = alu_result_i;
            SRC_MEM: src_value = load_value;
            SRC_PC4: src_value = pc_plus4_i;
            SRC_CSR: src_value = csr_rdata_i;
            default: src_value = alu_result_i;
        endcase
    end

    // Flush wins over both a new instruction and a same-cycle memory response.
    assign complete_idle = accept && (!is_mem || mem_rvalid_i);
    assign complete_wait = waiting && !flush_i && mem_rvalid_i;
    assign done          = complete_idle || complete_wait;
    assign done_rd       = waiting ? pend_rd    : dest_reg_i;
    assign done_we       = waiting ? pend_we    : reg_we_i;
    assign done_val      = waiting ? load_value : src_value;
    assign write_en      = done && done_we && (done_rd != '0);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state         <= IDLE;
            pend_rd       <= '0;
            pend_we       <= 1'b0;
            pend_size     <= '0;
            pend_unsigned <= 1'b0;
            pend_off      <= '0;
            rf_we_o       <= 1'b0;
            rf_waddr_o    <= '0;
            rf_wdata_o    <= '0;
            retire_o      <= 1'b0;
            instret_o     <= '0;
        end else begin
            retire_o <= done;
            rf_we_o  <= write_en;
            if (done) begin
                rf_waddr_o <= done_rd;
                instret_o  <= instret_o + CNT_ONE;
            end
            // Write data doubles as the forwarding value, so it only moves on a real write.
            if (write_en) begin
                rf_wdata_o <= done_val;
            end
            case (state)
                IDLE: begin
                    if (accept && is_mem && !mem_rvalid_i) begin
                        pend_rd       <= dest_reg_i;
                        pend_we       <= reg_we_i;
                        pend_size     <= load_size_i;
                        pend_unsigned <= load_unsigned_i;
                        pend_off      <= alu_result_i[OFF_WIDTH-1:0];
                        state         <= WAIT_MEM;
                    end
                end
                WAIT_MEM: begin
                    if (flush_i || mem_rvalid_i) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_wb_unit.sv
// Directed bench for wb_unit: a table of single-cycle instructions plus hand sequences for
// late loads, flushes, reset during a load and instret wrap-around.
module tb_wb_unit;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        flush_i;
    logic        valid_i;
    logic [1:0]  src_sel_i;
    logic        reg_we_i;
    logic [4:0]  dest_reg_i;
    logic [31:0] alu_result_i;
    logic [31:0] pc_plus4_i;
    logic [31:0] csr_rdata_i;
    logic [1:0]  load_size_i;
    logic        load_unsigned_i;
    logic        mem_rvalid_i;
    logic [31:0] mem_rdata_i;

    logic        ready_o;
    logic        rf_we_o;
    logic [4:0]  rf_waddr_o;
    logic [31:0] rf_wdata_o;
    logic        load_pending_o;
    logic [4:0]  pending_reg_o;
    logic        retire_o;
    logic [63:0] instret_o;

    logic        s_ready;
    logic        s_rf_we;
    logic [4:0]  s_rf_waddr;
    logic [31:0] s_rf_wdata;
    logic        s_load_pending;
    logic [4:0]  s_pending_reg;
    logic        s_retire;
    logic [3:0]  s_instret;

    int total = 0;
    int bad = 0;
    longint exp_instret = 0;

    always #5 clk_i = ~clk_i;

    wb_unit dut (
        .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i), .valid_i(valid_i), .ready_o(ready_o),
        .src_sel_i(src_sel_i), .reg_we_i(reg_we_i), .dest_reg_i(dest_reg_i),
        .alu_result_i(alu_result_i), .pc_plus4_i(pc_plus4_i), .csr_rdata_i(csr_rdata_i),
        .load_size_i(load_size_i), .load_unsigned_i(load_unsigned_i),
        .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i),
        .rf_we_o(rf_we_o), .rf_waddr_o(rf_waddr_o), .rf_wdata_o(rf_wdata_o),
        .load_pending_o(load_pending_o), .pending_reg_o(pending_reg_o),
        .retire_o(retire_o), .instret_o(instret_o)
    );

    wb_unit #(.CNT_WIDTH(4)) dut_small (
        .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i), .valid_i(valid_i), .ready_o(s_ready),
        .src_sel_i(src_sel_i), .reg_we_i(reg_we_i), .dest_reg_i(dest_reg_i),
        .alu_result_i(alu_result_i), .pc_plus4_i(pc_plus4_i), .csr_rdata_i(csr_rdata_i),
        .load_size_i(load_size_i), .load_unsigned_i(load_unsigned_i),
        .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i),
        .rf_we_o(s_rf_we), .rf_waddr_o(s_rf_waddr), .rf_wdata_o(s_rf_wdata),
        .load_pending_o(s_load_pending), .pending_reg_o(s_pending_reg),
        .retire_o(s_retire), .instret_o(s_instret)
    );

    typedef struct {
        logic [1:0]  src;
        logic        we;
        logic [4:0]  rd;
        logic [31:0] alu;
        logic [31:0] pc4;
        logic [31:0] csr;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] rdata;
        logic        exp_we;
        logic [31:0] exp_wdata;
    } vec_t;

    vec_t vecs[13];

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        src_sel_i       = v.src;
        reg_we_i        = v.we;
        dest_reg_i      = v.rd;
        alu_result_i    = v.alu;
        pc_plus4_i      = v.pc4;
        csr_rdata_i     = v.csr;
        load_size_i     = v.size;
        load_unsigned_i = v.uns;
        mem_rdata_i     = v.rdata;
        mem_rvalid_i    = 1'b1;
        valid_i         = 1'b1;
    endtask

    task automatic idleInputs();
        valid_i      = 1'b0;
        flush_i      = 1'b0;
        mem_rvalid_i = 1'b0;
    endtask

    task automatic afterEdge();
        @(posedge clk_i);
        #1;
    endtask

    task automatic startLoad(input logic [4:0] rd, input logic [1:0] size, input logic uns,
                             input logic [31:0] off);
        @(negedge clk_i);
        valid_i         = 1'b1;
        flush_i         = 1'b0;
        src_sel_i       = 2'd1;
        reg_we_i        = 1'b1;
        dest_reg_i      = rd;
        load_size_i     = size;
        load_unsigned_i = uns;
        alu_result_i    = off;
        mem_rvalid_i    = 1'b0;
        afterEdge();
    endtask

    initial begin
        vecs[0]  = '{2'd0, 1'b1, 5'd5,  32'h0000_1234, 32'h0, 32'h0, 2'd0, 1'b0, 32'hFFFF_FFFF, 1'b1, 32'h0000_1234};
        vecs[1]  = '{2'd1, 1'b1, 5'd6,  32'h0000_0003, 32'h0, 32'h0, 2'd0, 1'b0, 32'h80FF_0000, 1'b1, 32'hFFFF_FF80};
        vecs[2]  = '{2'd1, 1'b1, 5'd8,  32'h0000_0002, 32'h0, 32'h0, 2'd1, 1'b1, 32'hBEEF_0000, 1'b1, 32'h0000_BEEF};
        vecs[3]  = '{2'd2, 1'b1, 5'd0,  32'h0000_0011, 32'h100, 32'h0, 2'd0, 1'b0, 32'h0, 1'b0, 32'h0000_BEEF};
        vecs[4]  = '{2'd3, 1'b1, 5'd7,  32'h0000_0022, 32'h0, 32'hC0DE, 2'd0, 1'b0, 32'h0, 1'b1, 32'h0000_C0DE};
        vecs[5]  = '{2'd1, 1'b1, 5'd10, 32'h0000_0001, 32'h0, 32'h0, 2'd1, 1'b0, 32'h1234_8001, 1'b1, 32'hFFFF_8001};
        vecs[6]  = '{2'd1, 1'b1, 5'd11, 32'h0000_0001, 32'h0, 32'h0, 2'd0, 1'b1, 32'h0000_AB00, 1'b1, 32'h0000_00AB};
        vecs[7]  = '{2'd1, 1'b1, 5'd12, 32'h0000_0000, 32'h0, 32'h0, 2'd2, 1'b0, 32'hDEAD_BEEF, 1'b1, 32'hDEAD_BEEF};
        vecs[8]  = '{2'd1, 1'b1, 5'd13, 32'h0000_0000, 32'h0, 32'h0, 2'd3, 1'b0, 32'h8765_4321, 1'b1, 32'h8765_4321};
        vecs[9]  = '{2'd0, 1'b0, 5'd9,  32'h0000_5555, 32'h0, 32'h0, 2'd0, 1'b0, 32'h0, 1'b0, 32'h8765_4321};
        vecs[10] = '{2'd1, 1'b1, 5'd14, 32'h0000_0000, 32'h0, 32'h0, 2'd0, 1'b0, 32'h0000_007F, 1'b1, 32'h0000_007F};
        vecs[11] = '{2'd1, 1'b1, 5'd15, 32'h0000_0002, 32'h0, 32'h0, 2'd0, 1'b0, 32'h0080_0000, 1'b1, 32'hFFFF_FF80};
        vecs[12] = '{2'd2, 1'b1, 5'd1,  32'h0000_0000, 32'h104, 32'h0, 2'd0, 1'b0, 32'h0, 1'b1, 32'h0000_0104};

        rst_i = 1'b1;
        idleInputs();
        src_sel_i = 2'd0; reg_we_i = 1'b0; dest_reg_i = '0; alu_result_i = '0;
        pc_plus4_i = '0; csr_rdata_i = '0; load_size_i = '0; load_unsigned_i = 1'b0;
        mem_rdata_i = '0;

        afterEdge();
        afterEdge();
        checkOutput("ready_in_reset", 64'(ready_o), 64'd0);
        @(negedge clk_i);
        rst_i = 1'b0;
        afterEdge();
        checkOutput("rst_rf_we", 64'(rf_we_o), 64'd0);
        checkOutput("rst_retire", 64'(retire_o), 64'd0);
        checkOutput("rst_instret", instret_o, 64'd0);
        checkOutput("rst_wdata", 64'(rf_wdata_o), 64'd0);
        checkOutput("rst_pending", 64'(load_pending_o), 64'd0);
        checkOutput("rst_ready", 64'(ready_o), 64'd1);

        // Back-to-back single-cycle instructions, including same-cycle loads.
        for (int i = 0; i < 13; i++) begin
            @(negedge clk_i);
            applyStimulus(vecs[i]);
            afterEdge();
            exp_instret++;
            checkOutput($sformatf("vec%0d_we", i), 64'(rf_we_o), 64'(vecs[i].exp_we));
            checkOutput($sformatf("vec%0d_waddr", i), 64'(rf_waddr_o), 64'(vecs[i].rd));
            checkOutput($sformatf("vec%0d_wdata", i), 64'(rf_wdata_o), 64'(vecs[i].exp_wdata));
            checkOutput($sformatf("vec%0d_retire", i), 64'(retire_o), 64'd1);
            checkOutput($sformatf("vec%0d_instret", i), instret_o, 64'(exp_instret));
        end
        @(negedge clk_i);
        idleInputs();
        afterEdge();
        checkOutput("idle_retire", 64'(retire_o), 64'd0);
        checkOutput("idle_we", 64'(rf_we_o), 64'd0);
        checkOutput("idle_instret", instret_o, 64'(exp_instret));

        // Flush in IDLE drops the presented instruction.
        @(negedge clk_i);
        valid_i = 1'b1; flush_i = 1'b1; src_sel_i = 2'd0; reg_we_i = 1'b1;
        dest_reg_i = 5'd3; alu_result_i = 32'h99;
        afterEdge();
        checkOutput("idle_flush_retire", 64'(retire_o), 64'd0);
        checkOutput("idle_flush_instret", instret_o, 64'(exp_instret));

        // LBU offset 1 with the response three cycles late; an ALU op waits behind it.
        startLoad(5'd12, 2'd0, 1'b1, 32'h1);
        @(negedge clk_i);
        valid_i = 1'b1; flush_i = 1'b0; src_sel_i = 2'd0; reg_we_i = 1'b1; dest_reg_i = 5'd3;
        alu_result_i = 32'h56; load_size_i = 2'd2; load_unsigned_i = 1'b0;
        for (int c = 0; c < 3; c++) begin
            checkOutput($sformatf("late%0d_ready", c), 64'(ready_o), 64'd0);
            checkOutput($sformatf("late%0d_pending", c), 64'(load_pending_o), 64'd1);
            checkOutput($sformatf("late%0d_preg", c), 64'(pending_reg_o), 64'd12);
            checkOutput($sformatf("late%0d_retire", c), 64'(retire_o), 64'd0);
            if (c == 2) begin
                @(negedge clk_i);
                mem_rvalid_i = 1'b1;
                mem_rdata_i  = 32'h0000_C300;
            end
            afterEdge();
        end
        exp_instret++;
        checkOutput("late_we", 64'(rf_we_o), 64'd1);
        checkOutput("late_waddr", 64'(rf_waddr_o), 64'd12);
        checkOutput("late_wdata", 64'(rf_wdata_o), 64'h0000_00C3);
        checkOutput("late_pending_clr", 64'(load_pending_o), 64'd0);
        checkOutput("late_ready", 64'(ready_o), 64'd1);
        checkOutput("late_instret", instret_o, 64'(exp_instret));
        @(negedge clk_i);
        mem_rvalid_i = 1'b0;
        afterEdge();
        exp_instret++;
        checkOutput("after_alu_waddr", 64'(rf_waddr_o), 64'd3);
        checkOutput("after_alu_wdata", 64'(rf_wdata_o), 64'h56);
        checkOutput("after_alu_instret", instret_o, 64'(exp_instret));

        // Flush during WAIT_MEM with a simultaneous response, then a stray response.
        @(negedge clk_i);
        idleInputs();
        startLoad(5'd14, 2'd2, 1'b0, 32'h0);
        checkOutput("fl_pending", 64'(load_pending_o), 64'd1);
        checkOutput("fl_preg", 64'(pending_reg_o), 64'd14);
        @(negedge clk_i);
        valid_i = 1'b0; flush_i = 1'b1; mem_rvalid_i = 1'b1; mem_rdata_i = 32'h1111_2222;
        afterEdge();
        checkOutput("fl_we", 64'(rf_we_o), 64'd0);
        checkOutput("fl_retire", 64'(retire_o), 64'd0);
        checkOutput("fl_instret", instret_o, 64'(exp_instret));
        checkOutput("fl_ready", 64'(ready_o), 64'd1);
        checkOutput("fl_pending_clr", 64'(load_pending_o), 64'd0);
        @(negedge clk_i);
        flush_i = 1'b0;
        afterEdge();
        checkOutput("stray_retire", 64'(retire_o), 64'd0);
        checkOutput("stray_instret", instret_o, 64'(exp_instret));

        // Reset while a load is outstanding; the late response must be ignored.
        @(negedge clk_i);
        idleInputs();
        startLoad(5'd20, 2'd0, 1'b0, 32'h0);
        checkOutput("rl_pending", 64'(load_pending_o), 64'd1);
        @(negedge clk_i);
        valid_i = 1'b0; rst_i = 1'b1;
        afterEdge();
        exp_instret = 0;
        checkOutput("rl_ready", 64'(ready_o), 64'd0);
        checkOutput("rl_pending", 64'(load_pending_o), 64'd0);
        checkOutput("rl_preg", 64'(pending_reg_o), 64'd0);
        checkOutput("rl_we", 64'(rf_we_o), 64'd0);
        checkOutput("rl_waddr", 64'(rf_waddr_o), 64'd0);
        checkOutput("rl_wdata", 64'(rf_wdata_o), 64'd0);
        checkOutput("rl_retire", 64'(retire_o), 64'd0);
        checkOutput("rl_instret", instret_o, 64'd0);
        @(negedge clk_i);
        rst_i = 1'b0; mem_rvalid_i = 1'b1; mem_rdata_i = 32'hFF;
        afterEdge();
        checkOutput("rl_late_retire", 64'(retire_o), 64'd0);
        checkOutput("rl_late_ready", 64'(ready_o), 64'd1);
        checkOutput("rl_late_instret", instret_o, 64'd0);

        // 17 back-to-back ALU ops: one retire per cycle, 4-bit counter wraps to 1.
        for (int i = 0; i < 17; i++) begin
            @(negedge clk_i);
            valid_i = 1'b1; flush_i = 1'b0; mem_rvalid_i = 1'b0; src_sel_i = 2'd0;
            reg_we_i = 1'b1; dest_reg_i = 5'd2; alu_result_i = 32'(i + 100);
            afterEdge();
            exp_instret++;
            checkOutput($sformatf("tp%0d_retire", i), 64'(retire_o), 64'd1);
            checkOutput($sformatf("tp%0d_wdata", i), 64'(rf_wdata_o), 64'(i + 100));
        end
        checkOutput("wrap_main_instret", instret_o, 64'(exp_instret));
        checkOutput("wrap_small_instret", 64'(s_instret), 64'(exp_instret % 16));

        @(negedge clk_i);
        idleInputs();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/wb_unit.md
Name: wb_unit

Overview:
- Parametrised writeback stage for the riscv_cpu pipeline, replacing the purely combinational writeback mux.
- Selects among ALU, load, PC+4 and CSR results.
- Performs load byte/half/word(/double) extraction with sign or zero extension.
- Holds the instruction while a variable-latency data-memory response is outstanding, backpressuring MEM.
- Drives a registered register-file write, forwarding/hazard information, and the retired-instruction counter.

Parameters:
- DATA_WIDTH, 32, datapath width; legal values are 32 or 64 only.
- REG_ADDR_WIDTH, 5, register index width.
- CNT_WIDTH, 64, instret counter width.
- OFF_WIDTH, $clog2(DATA_WIDTH/8), byte-offset width (derived; not overridable).

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- flush_i  in  1  kill instruction in this stage
- valid_i  in  1  MEM stage presents an instruction
- ready_o  out  1  stage accepts an instruction this cycle
- src_sel_i  in  2  result source: 0=ALU, 1=MEM, 2=PC4, 3=CSR
- reg_we_i  in  1  instruction writes rd
- dest_reg_i  in  REG_ADDR_WIDTH  rd
- alu_result_i  in  DATA_WIDTH  ALU result; its low OFF_WIDTH bits are the load byte offset
- pc_plus4_i  in  DATA_WIDTH  link value
- csr_rdata_i  in  DATA_WIDTH  CSR read value
- load_size_i  in  2  0=B, 1=H, 2=W, 3=D (D only when DATA_WIDTH=64)
- load_unsigned_i  in  1  zero-extend when 1
- mem_rvalid_i  in  1  data-memory read response valid
- mem_rdata_i  in  DATA_WIDTH  data-memory read data (aligned word/dword)
- rf_we_o  out  1  register-file write enable
- rf_waddr_o  out  REG_ADDR_WIDTH  write address
- rf_wdata_o  out  DATA_WIDTH  write data; also the forwarding value
- load_pending_o  out  1  load waiting for memory data
- pending_reg_o  out  REG_ADDR_WIDTH  rd of the pending load
- retire_o  out  1  one-cycle pulse per completed instruction
- instret_o  out  CNT_WIDTH  retired-instruction count

Behaviour:
- Reset behaviour:
  - rst_i sampled on clk_i.
  - All registered outputs become 0, state becomes IDLE, instret_o becomes 0.
  - ready_o is 0 while rst_i is high.
  - Reset mid-load drops the load silently: no write, no retire.
- FSM states are IDLE and WAIT_MEM.
- ready_o = (state==IDLE) && !rst_i.
- Accept = valid_i && ready_o && !flush_i.
- IDLE transitions:
  - Accept with src_sel≠MEM: write next cycle, stay in IDLE.
  - Accept with src_sel=MEM and mem_rvalid_i=1 in the same cycle: write next cycle, stay in IDLE.
  - Accept with src_sel=MEM and mem_rvalid_i=0: capture rd, reg_we, size, unsigned and offset, then go to WAIT_MEM.
- WAIT_MEM transitions:
  - ready_o=0, load_pending_o=1, pending_reg_o = captured rd.
  - On mem_rvalid_i: write next cycle, go to IDLE.
  - load_pending_o is 0 in the write cycle.
- Flush rules:
  - flush_i has priority over valid_i and mem_rvalid_i.
  - In IDLE, flush_i drops the presented instruction.
  - In WAIT_MEM, flush_i returns to IDLE with no write and no retire; a same-cycle rvalid is discarded.
  - A later stray mem_rvalid_i is ignored.
- mem_rvalid_i while no load is accepted or pending is ignored.
- Write cycle (registered outputs, latency 1 from the completing edge):
  - retire_o=1.
  - rf_we_o = reg_we && (rd≠0).
  - rf_waddr_o = rd.
  - rf_wdata_o = selected value; rf_wdata_o holds its value when rf_we_o=0.
  - The cycle after, rf_we_o=0 and retire_o=0 unless another completion occurs.
- Load extraction, with off = offset:
  - B: rdata[8*off +: 8].
  - H: rdata[16*off[OFF_WIDTH-1:1] +: 16]; off[0] is ignored.
  - W: on 64-bit, rdata[32*off[2] +: 32]; on 32-bit, the full word.
  - D: full 64-bit data.
  - Extension is sign or zero per load_unsigned_i.
  - load_size=D on a 32-bit build is treated as W.
- instret_o:
  - Increments by 1 on every retire, including reg_we=0 and rd=0.
  - Wraps modulo 2^CNT_WIDTH.
- Back-to-back non-load instructions retire every cycle, with throughput 1/cycle.

Test Plan:
- ALU op, rd=5, alu=0x1234, valid 1 cycle → next cycle rf_we=1, waddr=5, wdata=0x1234, retire=1, instret=1.
- LB offset 3, unsigned=0, rdata=0x80FF_0000 arriving same cycle → wdata=0xFFFF_FF80; LHU offset 2, rdata=0xBEEF_0000 → 0x0000_BEEF.
- Load with rvalid 3 cycles late → ready_o=0 and load_pending_o=1, pending_reg=rd for 3 cycles; write on the cycle after rvalid; following ALU op accepted only then.
- flush_i during WAIT_MEM with simultaneous rvalid → no rf_we, no retire, instret unchanged, ready_o=1 next cycle.
- rd=0 with PC4 source → rf_we=0, retire=1, instret increments; CSR source rd=7, csr=0xC0DE → wdata=0xC0DE.
- CNT_WIDTH=4, 17 retires → instret=1; rst_i asserted while in WAIT_MEM → all outputs 0, IDLE, a late rvalid is ignored.
